dmem_word_access_ctrl: RTL and testbench

Memory-stage access controller between the EX/MEM pipeline register and the byte-wide data memory. It turns one 32-bit load or store into four sequential byte accesses, little-endian. While an access is in progress it stalls the pipeline, then returns the assembled load word. It also flags misaligned, out-of-range and conflicting requests without touching memory.

---
 rtl/dmem_word_access_ctrl.sv | 115 +++++++++++
 tb/tb_dmem_word_access_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/dmem_word_access_ctrl.sv
// Memory-stage controller: splits one 32-bit load/store into four little-endian
// byte accesses on a byte-wide data memory, stalling the pipeline meanwhile.
module dmem_word_access_ctrl #(
  parameter int unsigned MEM_DEPTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_read_i,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  stall_o,
  output logic [31:0]           rdata_o,
  output logic                  rdata_valid_o,
  output logic                  err_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  input  logic [7:0]            mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  // One extra bit so addr_i+3 cannot wrap past the range check.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           shadow_q, shadow_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  is_load_q, is_load_d;

  logic any_req;
  logic legal;
  logic go;
  logic bad;

  assign any_req = req_read_i | req_write_i;
  assign legal   = (addr_i[1:0] == 2'b00)
                && (({1'b0, addr_i} + (ADDR_WIDTH+1)'(3)) < DEPTH_EXT)
                && !(req_read_i && req_write_i);
  assign go      = (state_q == IDLE) && any_req && legal;
  assign bad     = (state_q == IDLE) && any_req && !legal;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    shadow_d  = shadow_q;
    rdata_d   = rdata_q;
    is_load_d = is_load_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          cnt_d     = '0;
          is_load_d = req_read_i;
          state_d   = req_read_i ? RD : WR;
        end
      end
      RD: begin
        shadow_d[8*cnt_q +: 8] = mem_rdata_i;
        cnt_d = cnt_q + 2'd1;
        // The last byte is merged straight into rdata so it is valid in DONE.
        if (cnt_q == 2'd3) begin
          rdata_d = {mem_rdata_i, shadow_q[23:0]};
          state_d = DONE;
        end
      end
      WR: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      shadow_q  <= '0;
      rdata_q   <= '0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      shadow_q  <= shadow_d;
      rdata_q   <= rdata_d;
      is_load_q <= is_load_d;
    end
  end

  // Request-driven IDLE outputs are masked by reset so every output reads 0 during reset.
  assign stall_o       = (rst_i && go) || (state_q == RD) || (state_q == WR);
  assign err_o         = rst_i && bad;
  assign mem_read_o    = (state_q == RD);
  assign mem_write_o   = (state_q == WR);
  assign mem_addr_o    = ((state_q == RD) || (state_q == WR)) ? addr_q + ADDR_WIDTH'(cnt_q) : '0;
  assign mem_wdata_o   = (state_q == WR) ? wdata_q[8*cnt_q +: 8] : '0;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = (state_q == DONE) && is_load_q;

endmodule

// File: tb/tb_dmem_word_access_ctrl.sv
// Directed bench for dmem_word_access_ctrl with a 32-byte memory model.
module tb_dmem_word_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_read_i, req_write_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, rdata_valid_o, err_o, mem_read_o, mem_write_o;
  logic [31:0] rdata_o, mem_addr_o;
  logic [7:0]  mem_wdata_o, mem_rdata_i;

  logic [7:0]  mem [0:31];
  int          checks = 0;
  int          errors = 0;
  int          n_stall = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk_i = ~clk_i;

  dmem_word_access_ctrl #(.MEM_DEPTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_read_i(req_read_i), .req_write_i(req_write_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .err_o(err_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always @(posedge clk_i) if (mem_write_o) mem[mem_addr_o[4:0]] <= mem_wdata_o;
  assign mem_rdata_i = mem[mem_addr_o[4:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {stall, mem_read, mem_write, err, rdata_valid}
  function automatic logic [4:0] ctl();
    return {stall_o, mem_read_o, mem_write_o, err_o, rdata_valid_o};
  endfunction

  task automatic idle_chk(input string tag);
    @(negedge clk_i); #1;
    chk(tag, ctl(), 5'b00000);
    chk({tag, "_rdata"}, rdata_o, exp_rdata);
  endtask

  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_word);
    @(negedge clk_i);
    req_write_i = wr; req_read_i = !wr; addr_i = a; wdata_i = d;
    #1;
    chk("accept_ctl", ctl(), 5'b10000);
    n_stall += int'(stall_o);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); #1;
      chk("byte_ctl", ctl(), wr ? 5'b10100 : 5'b11000);
      chk("byte_addr", mem_addr_o, a + 32'(k));
      if (wr) chk("byte_wdata", mem_wdata_o, exp_word[8*k +: 8]);
      n_stall += int'(stall_o);
    end
    @(negedge clk_i); #1;
    if (!wr) exp_rdata = exp_word;
    chk("done_ctl", ctl(), wr ? 5'b00000 : 5'b00001);
    chk("done_rdata", rdata_o, exp_rdata);
    n_stall += int'(stall_o);
    req_write_i = 1'b0; req_read_i = 1'b0;
  endtask

  task automatic illegal(input string tag, input logic rd, input logic wr, input logic [31:0] a);
    @(negedge clk_i);
    req_read_i = rd; req_write_i = wr; addr_i = a; wdata_i = 32'hDEADBEEF;
    #1;
    chk(tag, ctl(), 5'b00010);
    chk({tag, "_rdata"}, rdata_o, exp_rdata);
    req_read_i = 1'b0; req_write_i = 1'b0;
    idle_chk({tag, "_after"});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    rst_i = 1'b0; req_read_i = 1'b0; req_write_i = 1'b0; addr_i = '0; wdata_i = '0;
    #2;
    chk("reset_outputs", {ctl(), mem_addr_o, mem_wdata_o, rdata_o}, '0);
    @(negedge clk_i); rst_i = 1'b1;
    idle_chk("idle_after_reset");

    n_stall = 0;
    access(1'b1, 32'd8, 32'h11223344, 32'h11223344);
    chk("store8_stall_cycles", n_stall, 5);
    chk("store8_mem", {mem[11], mem[10], mem[9], mem[8]}, 32'h11223344);

    access(1'b0, 32'd8, 32'h0, 32'h11223344);
    idle_chk("load8_valid_one_cycle");

    illegal("misaligned_load6", 1'b1, 1'b0, 32'd6);
    illegal("range_store32", 1'b0, 1'b1, 32'd32);
    access(1'b1, 32'd28, 32'hCAFEF00D, 32'hCAFEF00D);
    chk("store28_mem", {mem[31], mem[30], mem[29], mem[28]}, 32'hCAFEF00D);
    illegal("both_req_addr0", 1'b1, 1'b1, 32'd0);

    // Store at 0, then assert reset mid-cycle during the third byte cycle.
    @(negedge clk_i);
    req_write_i = 1'b1; addr_i = 32'd0; wdata_i = 32'hAABBCCDD;
    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    exp_rdata = '0;
    chk("midstore_reset_outputs", {ctl(), mem_addr_o, mem_wdata_o, rdata_o}, '0);
    req_write_i = 1'b0;
    @(negedge clk_i); #1;
    chk("midstore_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'h0000CCDD);
    rst_i = 1'b1;
    idle_chk("idle_after_midreset");
    access(1'b0, 32'd0, 32'h0, 32'h0000CCDD);

    n_stall = 0;
    access(1'b1, 32'd4, 32'h55667788, 32'h55667788);
    access(1'b0, 32'd4, 32'h0, 32'h55667788);
    chk("b2b_stall_cycles", n_stall, 10);
    idle_chk("b2b_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
